// File: rtl/bus_gen_arbiter.sv
// Multi-bus round-robin arbiter: pops a granted device's FWFT FIFO and pushes the packet to its destination(s).
// Optional macro BCAST_TO_SRC_EN: broadcast packets are also pushed back to the source device.
module bus_gen_arbiter #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [bits*drvrs-1:0]           pndng,
  output logic [bits*drvrs-1:0]           pop,
  input  logic [pckg_sz*bits*drvrs-1:0]   D_pop,
  output logic [bits*drvrs-1:0]           push,
  output logic [pckg_sz*bits*drvrs-1:0]   D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  // First requesting device at or after start, wrapping past the last device.
  function automatic logic [IW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                            input logic [IW-1:0]    start);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < drvrs; i++) begin
      idx = int'(start) + i;
      if (idx >= drvrs) idx = idx - drvrs;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
    return pick;
  endfunction

  function automatic logic [drvrs-1:0] dest_mask(input logic [7:0]    id,
                                                 input logic [IW-1:0] src);
    logic [drvrs-1:0] m;
    m = '0;
    if (id == broadcast) begin
`ifdef BCAST_TO_SRC_EN
      m = '1;
`else
      m      = '1;
      m[src] = 1'b0;
`endif
    end else if (int'(id) < drvrs) begin
      m[id[IW-1:0]] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [drvrs-1:0] onehot(input logic [IW-1:0] idx);
    logic [drvrs-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t                         state, state_nxt;
    logic [IW-1:0]                  ptr, ptr_nxt;
    logic [IW-1:0]                  grant, grant_nxt;
    logic [drvrs-1:0]               pop_r, pop_nxt;
    logic [drvrs-1:0]               push_r, push_nxt;
    logic [pckg_sz-1:0]             pkt, pkt_nxt;
    logic [pckg_sz-1:0]             head;
    logic [drvrs-1:0]               req;
    logic [drvrs-1:0][pckg_sz-1:0]  lanes;

    assign req   = pndng[b*drvrs +: drvrs];
    assign lanes = D_pop[b*drvrs*pckg_sz +: drvrs*pckg_sz];
    assign head  = lanes[grant];

    always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      pop_nxt   = '0;
      push_nxt  = '0;
      pkt_nxt   = pkt;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_nxt = rr_pick(req, ptr);
            pop_nxt   = onehot(grant_nxt);
            state_nxt = POP;
          end
        end
        POP: begin
          // The FWFT head is still valid on the edge that consumes it.
          pkt_nxt   = head;
          push_nxt  = dest_mask(head[pckg_sz-1 -: 8], grant);
          state_nxt = PUSH;
        end
        PUSH: begin
          ptr_nxt   = (grant == IW'(drvrs - 1)) ? '0 : grant + IW'(1);
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        ptr    <= '0;
        grant  <= '0;
        pop_r  <= '0;
        push_r <= '0;
        pkt    <= '0;
      end else begin
        state  <= state_nxt;
        ptr    <= ptr_nxt;
        grant  <= grant_nxt;
        pop_r  <= pop_nxt;
        push_r <= push_nxt;
        pkt    <= pkt_nxt;
      end
    end

    assign pop[b*drvrs +: drvrs]                    = pop_r;
    assign push[b*drvrs +: drvrs]                   = push_r;
    assign D_push[b*drvrs*pckg_sz +: drvrs*pckg_sz] = {drvrs{pkt}};
  end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Randomized bench for bus_gen_arbiter: device FIFOs plus a transaction-schedule reference model.
module tb_bus_gen_arbiter;
  localparam int DRV  = 4;
  localparam int PW   = 16;
  localparam int NB   = 1;
  localparam int NCYC = 3000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NB*DRV-1:0]    pndng, pop, push;
  logic [PW*NB*DRV-1:0] D_pop, D_push;

  always #5 clk = ~clk;

  bus_gen_arbiter #(
    .bits(NB), .drvrs(DRV), .pckg_sz(PW), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .pop(pop),
    .D_pop(D_pop), .push(push), .D_push(D_push)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Device-side FIFOs: packet count and current head word.
  int          cnt    [DRV];
  logic [PW-1:0] head [DRV];
  logic        popped [DRV];

  // Expected outputs scheduled per cycle.
  logic [DRV-1:0] exp_pop  [NCYC+4];
  logic [DRV-1:0] exp_push [NCYC+4];
  logic           dp_set   [NCYC+4];
  logic [PW-1:0]  dp_val   [NCYC+4];
  logic [PW-1:0]  cur_dp;
  int             ptr, free_at, g, idx;
  logic [7:0]     id;

  function automatic logic [PW-1:0] rand_pkt();
    logic [7:0]    rid;
    logic [PW-9:0] pl;
    int            r;
    r = $urandom_range(0, 9);
    if (r < 2)      rid = 8'hFF;
    else if (r < 8) rid = 8'($urandom_range(0, DRV - 1));
    else            rid = 8'($urandom_range(DRV, 254));
    pl = (PW-8)'($urandom);
    return {rid, pl};
  endfunction

  // Who should receive a packet with this destination ID from source src.
  function automatic logic [DRV-1:0] expected_dest(input logic [7:0] did, input int src);
    logic [DRV-1:0] all;
    all = '1;
    if (did == 8'hFF) begin
`ifdef BCAST_TO_SRC_EN
      return all;
`else
      return all & ~(DRV'(1) << src);
`endif
    end
    if (int'(did) < DRV) return DRV'(1) << did;
    return '0;
  endfunction

  task automatic drive_inputs();
    for (int d = 0; d < DRV; d++) begin
      pndng[d]           = (cnt[d] > 0);
      D_pop[d*PW +: PW]  = head[d];
    end
  endtask

  initial begin
    reset  = 1'b1;
    cur_dp = '0;
    ptr    = 0;
    free_at = 0;
    for (int i = 0; i < NCYC + 4; i++) begin
      exp_pop[i]  = '0;
      exp_push[i] = '0;
      dp_set[i]   = 1'b0;
      dp_val[i]   = '0;
    end
    // Every device pending with valid unicast packets for the round-robin opening.
    for (int d = 0; d < DRV; d++) begin
      cnt[d]    = 2;
      head[d]   = {8'((d + 1) % DRV), 8'($urandom)};
      popped[d] = 1'b0;
    end
    drive_inputs();

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // FIFO pops seen last cycle took effect on the edge just passed.
      for (int d = 0; d < DRV; d++) begin
        if (popped[d]) begin
          if (cnt[d] > 0) cnt[d]--;
          head[d] = rand_pkt();
        end
      end
      if (dp_set[cyc]) cur_dp = dp_val[cyc];
      check("pop",   pop,    exp_pop[cyc]);
      check("push",  push,   exp_push[cyc]);
      check("dpush", D_push, {DRV{cur_dp}});
      // Opening sequence: grants 0,1,2,3,0 one every 3 cycles after reset release.
      if (cyc >= 5 && cyc <= 17 && (cyc - 5) % 3 == 0)
        check("rr_grant", pop, DRV'(1) << (((cyc - 5) / 3) % DRV));
      for (int d = 0; d < DRV; d++) popped[d] = pop[d];

      if (cyc < 4)
        reset = 1'b1;
      else if (cyc > 50 && exp_pop[cyc] != '0 && $urandom_range(0, 15) == 0)
        reset = 1'b1;
      else if (cyc > 50 && $urandom_range(0, 99) == 0)
        reset = 1'b1;
      else
        reset = 1'b0;

      if (cyc > 20 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, DRV - 1);
        if (cnt[idx] == 0) head[idx] = rand_pkt();
        if (cnt[idx] < 4) cnt[idx]++;
      end
      drive_inputs();

      if (reset) begin
        for (int i = cyc + 1; i <= cyc + 3; i++) begin
          exp_pop[i]  = '0;
          exp_push[i] = '0;
          dp_set[i]   = 1'b0;
        end
        dp_set[cyc+1] = 1'b1;
        dp_val[cyc+1] = '0;
        ptr     = 0;
        free_at = cyc + 1;
      end else if (cyc >= free_at && pndng != '0) begin
        g = -1;
        for (int i = 0; i < DRV; i++) begin
          idx = (ptr + i) % DRV;
          if (g < 0 && pndng[idx]) g = idx;
        end
        id = head[g][PW-1 -: 8];
        exp_pop[cyc+1]  = DRV'(1) << g;
        exp_push[cyc+2] = expected_dest(id, g);
        dp_set[cyc+2]   = 1'b1;
        dp_val[cyc+2]   = head[g];
        ptr     = (g + 1) % DRV;
        free_at = cyc + 3;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
